// File: rtl/calc_ctrl_if.sv
// Operand entry, adder hookup and display signals of the two-operand calculator.
// The slave side is the controller; the master side is the buttons, switches and external adder.
interface calc_ctrl_if;
  logic       btn_load;
  logic       btn_clr;
  logic [7:0] sw;
  logic [8:0] sum_in;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       busy;
  logic       done;
  logic [3:0] fnd_com;
  logic [3:0] digit_bcd;

  modport master (
    output btn_load, btn_clr, sw, sum_in,
    input  op_a, op_b, busy, done, fnd_com, digit_bcd
  );

  modport slave (
    input  btn_load, btn_clr, sw, sum_in,
    output op_a, op_b, busy, done, fnd_com, digit_bcd
  );
endinterface

// File: rtl/calc_ctrl.sv
// Two-operand add controller with binary-to-BCD conversion and a 4-digit multiplexed display.
// Latency: done pulses 10 edges after the second operand load (1 CALC + 9 CONV cycles).
// Backpressure: none; loads are dropped while busy, btn_clr always wins.
module calc_ctrl #(
  parameter int REF_CNT = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  calc_ctrl_if.slave  bus
);

  localparam int DIV_W = (REF_CNT > 1) ? $clog2(REF_CNT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    A_DONE,
    CALC,
    CONV,
    SHOW
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [7:0]  op_a_q;
  logic [7:0]  op_b_q;
  logic [8:0]  result;
  logic [11:0] bcd;
  logic [20:0] shift_q;
  logic [20:0] shift_src;
  logic [20:0] shift_nxt;
  logic [3:0]  bit_cnt;
  logic        done_q;
  logic        conv_last;

  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic [1:0]       scan_sel;
  logic [3:0]       fnd_com_c;
  logic [3:0]       digit_c;

  // One double-dabble step: correct every BCD nibble >= 5, then shift left.
  function automatic logic [20:0] dabble(input logic [20:0] s);
    logic [20:0] t;
    t = s;
    if (t[12:9]  >= 4'd5) t[12:9]  = t[12:9]  + 4'd3;
    if (t[16:13] >= 4'd5) t[16:13] = t[16:13] + 4'd3;
    if (t[20:17] >= 4'd5) t[20:17] = t[20:17] + 4'd3;
    return t << 1;
  endfunction

  assign conv_last = (state == CONV) && (bit_cnt == 4'd8);
  // The first step starts from the freshly registered result rather than a preloaded shifter.
  assign shift_src = (bit_cnt == 4'd0) ? {12'd0, result} : shift_q;
  assign shift_nxt = dabble(shift_src);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.btn_clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.btn_load) state_nxt = A_DONE;
        A_DONE:  if (bus.btn_load) state_nxt = CALC;
        CALC:    state_nxt = CONV;
        CONV:    if (conv_last) state_nxt = SHOW;
        SHOW:    if (bus.btn_load) state_nxt = A_DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      result  <= '0;
      bcd     <= '0;
      shift_q <= '0;
      bit_cnt <= '0;
      done_q  <= 1'b0;
    end else if (bus.btn_clr) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      result  <= '0;
      bcd     <= '0;
      shift_q <= '0;
      bit_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, SHOW: begin
          if (bus.btn_load) op_a_q <= bus.sw;
        end
        A_DONE: begin
          if (bus.btn_load) op_b_q <= bus.sw;
        end
        CALC: begin
          result  <= bus.sum_in;
          bit_cnt <= '0;
        end
        CONV: begin
          shift_q <= shift_nxt;
          bit_cnt <= bit_cnt + 4'd1;
          if (conv_last) begin
            bcd    <= shift_nxt[20:9];
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Display scan runs off its own divider, untouched by the FSM.
  assign tick = (div_q == DIV_W'(REF_CNT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= '0;
      scan_sel <= '0;
    end else if (tick) begin
      div_q    <= '0;
      scan_sel <= scan_sel + 2'd1;
    end else begin
      div_q    <= div_q + DIV_W'(1);
    end
  end

  always_comb begin
    fnd_com_c = 4'b1110;
    digit_c   = bcd[3:0];
    case (scan_sel)
      2'd0: begin
        fnd_com_c = 4'b1110;
        digit_c   = bcd[3:0];
      end
      2'd1: begin
        fnd_com_c = 4'b1101;
        digit_c   = (bcd[11:4] == 8'h00) ? 4'hF : bcd[7:4];
      end
      2'd2: begin
        fnd_com_c = 4'b1011;
        digit_c   = (bcd[11:8] == 4'h0) ? 4'hF : bcd[11:8];
      end
      default: begin
        fnd_com_c = 4'b0111;
        digit_c   = 4'hF;
      end
    endcase
  end

  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.busy      = (state == CALC) || (state == CONV);
  assign bus.done      = done_q;
  assign bus.fnd_com   = fnd_com_c;
  assign bus.digit_bcd = digit_c;

endmodule

// File: tb/tb_calc_ctrl.sv
// Randomized bench for calc_ctrl: expected digits come from decimal arithmetic on the operand sum.
module tb_calc_ctrl;
  localparam int REF_CNT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  calc_ctrl_if bus ();

  calc_ctrl #(.REF_CNT(REF_CNT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External 8-bit adder.
  assign bus.sum_in = 9'(bus.op_a) + 9'(bus.op_b);

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic ld, input logic clr, input logic [7:0] v);
    @(negedge clk);
    bus.sw       = v;
    bus.btn_load = ld;
    bus.btn_clr  = clr;
    @(negedge clk);
    bus.btn_load = 1'b0;
    bus.btn_clr  = 1'b0;
  endtask

  // Scan all four digit positions and compare against the decimal value of r.
  task automatic check_display(input int r);
    logic [3:0] d [4];
    int h, t, o;
    int e [4];
    for (int i = 0; i < 4; i++) d[i] = 4'hx;
    for (int c = 0; c < 4 * REF_CNT + 4; c++) begin
      @(negedge clk);
      case (bus.fnd_com)
        4'b1110: d[0] = bus.digit_bcd;
        4'b1101: d[1] = bus.digit_bcd;
        4'b1011: d[2] = bus.digit_bcd;
        4'b0111: d[3] = bus.digit_bcd;
        default: check("fnd_com_legal", 32'(bus.fnd_com), 32'hE);
      endcase
    end
    h = r / 100;
    t = (r / 10) % 10;
    o = r % 10;
    e[0] = o;
    e[1] = (h == 0 && t == 0) ? 15 : t;
    e[2] = (h == 0) ? 15 : h;
    e[3] = 15;
    for (int i = 0; i < 4; i++)
      check($sformatf("digit%0d_r%0d", i, r), 32'(d[i]), 32'(e[i]));
  endtask

  // Load two operands; optionally fire a stray load somewhere inside the conversion.
  task automatic do_calc(input logic [7:0] a, input logic [7:0] b, input bit noise);
    int busy_n, done_at, done_n, pos;
    pos = $urandom_range(2, 8);
    pulse(1'b1, 1'b0, a);
    pulse(1'b1, 1'b0, b);
    busy_n  = bus.busy ? 1 : 0;
    done_at = -1;
    done_n  = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      if (noise && k == pos) begin
        bus.sw       = 8'($urandom);
        bus.btn_load = 1'b1;
      end
      if (noise && k == pos + 1) bus.btn_load = 1'b0;
    end
    check("busy_cycles", 32'(busy_n), 32'd10);
    check("done_edge", 32'(done_at), 32'd10);
    check("done_count", 32'(done_n), 32'd1);
    check("op_a", 32'(bus.op_a), 32'(a));
    check("op_b", 32'(bus.op_b), 32'(b));
    check_display(int'(a) + int'(b));
  endtask

  // Free-running scan: rotation order, period and a single active-low enable.
  task automatic scan_check(input int cycles);
    logic [3:0] prev;
    int last;
    prev = bus.fnd_com;
    last = -1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check("scan_onehot", 32'($countones(~bus.fnd_com)), 32'd1);
      if (bus.fnd_com != prev) begin
        check("scan_next", 32'(bus.fnd_com), 32'({prev[2:0], prev[3]}));
        if (last >= 0) check("scan_period", 32'(c - last), 32'(REF_CNT));
        last = c;
        prev = bus.fnd_com;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, done_n;
    bus.btn_load = 1'b0;
    bus.btn_clr  = 1'b0;
    bus.sw       = 8'd0;
    rst          = 1'b0;
    #33;
    check("rst_op_a", 32'(bus.op_a), 32'd0);
    check("rst_op_b", 32'(bus.op_b), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_fnd_com", 32'(bus.fnd_com), 32'hE);
    check("rst_digit", 32'(bus.digit_bcd), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed corners, with the display scan checked concurrently.
    fork
      do_calc(8'd200, 8'd100, 1'b0);
      scan_check(40);
    join
    do_calc(8'd255, 8'd255, 1'b0);
    do_calc(8'd0, 8'd0, 1'b0);
    do_calc(8'd57, 8'd43, 1'b1);

    // Clear collides with the second load: back to IDLE with zeroed operands.
    pulse(1'b1, 1'b0, 8'd77);
    pulse(1'b1, 1'b1, 8'd99);
    check("clr_op_a", 32'(bus.op_a), 32'd0);
    check("clr_op_b", 32'(bus.op_b), 32'd0);
    busy_n = 0;
    done_n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done) done_n++;
    end
    check("clr_busy", 32'(busy_n), 32'd0);
    check("clr_done", 32'(done_n), 32'd0);
    check_display(0);
    do_calc(8'd9, 8'd1, 1'b0);

    // Reset mid-conversion takes effect without a clock edge.
    pulse(1'b1, 1'b0, 8'd123);
    pulse(1'b1, 1'b0, 8'd45);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_op_a", 32'(bus.op_a), 32'd0);
    check("arst_op_b", 32'(bus.op_b), 32'd0);
    check("arst_fnd_com", 32'(bus.fnd_com), 32'hE);
    check("arst_digit", 32'(bus.digit_bcd), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    done_n = 0;
    busy_n = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.done) done_n++;
      if (bus.busy) busy_n++;
    end
    check("post_rst_done", 32'(done_n), 32'd0);
    check("post_rst_busy", 32'(busy_n), 32'd0);
    do_calc(8'd123, 8'd45, 1'b0);

    // Randomized chained calculations.
    for (int n = 0; n < 12; n++)
      do_calc(8'($urandom), 8'($urandom), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
